serial_port: RTL and testbench
==============================

SERIAL_PORT -- requirements
Module: serial_port

Interface
REQ-001 SHALL have parameter SCON_ADDRESS, default 8'h98, SCON SFR direct address.
REQ-002 SHALL have parameter SBUF_ADDRESS, default 8'h99, SBUF SFR direct address.
REQ-003 SHALL have port CPUClock  in  1  sole clock, all state on its rising edge.
REQ-004 SHALL have port RESET  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port DIR_RD_ADDRS  in  8  SFR read address.
REQ-006 SHALL have port DIR_WR_ADDRS  in  8  SFR write address.
REQ-007 SHALL have port WR_DATA  in  8  SFR write data.
REQ-008 SHALL have port RD_DATA  out  8  SFR read data, combinational.
REQ-009 SHALL have ports WR_EN, DIRECT_WR  in  1 each; a write occurs only when both are high and DIR_WR_ADDRS matches.
REQ-010 SHALL have port TERM_COUNT1  in  1  one-cycle timer-1 overflow pulse, the baud source for modes 1/3.
REQ-011 SHALL have port SMOD  in  1  baud doubler (PCON bit 7).
REQ-012 SHALL have port RXD_IN  in  1  asynchronous serial input.
REQ-013 SHALL have port TXD_OUT  out  1  serial output, idle high.
REQ-014 SHALL have port SER_INT_REQ  out  1  serial interrupt request, equal to SCON[1] OR SCON[0].

Function
REQ-015 SHALL map SCON bits as: [7:6] SM0:SM1 mode; [5] SM2; [4] REN; [3] TB8; [2] RB8; [1] TI; [0] RI.
REQ-016 SHALL drive RD_DATA with SCON at SCON_ADDRESS, the receive buffer at SBUF_ADDRESS, and 8'h00 at any other address.
REQ-017 SHALL support mode 1 (10-bit frame, variable baud), mode 2 (11-bit frame, fixed baud) and mode 3 (11-bit frame, variable baud); in mode 0 the port SHALL be idle with TXD_OUT=1 and SBUF writes ignored.
REQ-018 SHALL generate a sample tick (16 per bit): modes 1/3, every TERM_COUNT1 when SMOD=1 and every second TERM_COUNT1 when SMOD=0; mode 2, every 2 CPUClock cycles when SMOD=1 and every 4 when SMOD=0.
REQ-019 SHALL start transmission when SBUF is written while the transmitter is idle; an SBUF write while transmitting SHALL be ignored.
REQ-020 SHALL transmit, one bit per 16 ticks: start(0), D0..D7 LSB first, TB8 (modes 2/3 only, sampled at the SBUF write), stop(1).
REQ-021 SHALL set TI on the first tick of the stop bit; the transmitter SHALL stay busy until the stop bit completes.
REQ-022 SHALL double-synchronise RXD_IN (two flops) before any use.
REQ-023 receiver SHALL use states IDLE, START, DATA, BIT9, STOP; it SHALL leave IDLE only when REN=1 and a 1->0 transition is seen on the synchronised input.
REQ-024 SHALL take each bit value as the 2-of-3 majority of ticks 7, 8 and 9 within the bit.
REQ-025 SHALL return to IDLE without loading if the start-bit majority is 1 (false start).
REQ-026 in mode 1, at the stop-bit sample, SHALL load the buffer, set RB8 to the stop bit and set RI only if RI=0 and (SM2=0 or stop=1); otherwise the frame is discarded.
REQ-027 in modes 2/3, at the stop-bit sample, SHALL load the buffer, set RB8 to the ninth bit and set RI only if RI=0 and (SM2=0 or ninth bit=1).
REQ-028 SHALL return the receiver to IDLE after the stop sample and re-arm it for the next falling edge.
REQ-029 SHALL allow software to write all SCON bits; in the same cycle, a hardware set of TI, RI or RB8 SHALL take priority over the software value.
REQ-030 SHALL abort reception and return to IDLE immediately when REN is cleared; a transmission in progress SHALL continue.
REQ-031 SHALL, on a mode change mid-frame, abort both transmitter and receiver to idle with TXD_OUT=1 and leave TI and RI unchanged.

Reset
REQ-032 RESET=1 SHALL clear SCON, the receive buffer, the transmit shift register, the tick divider and both FSMs, with TXD_OUT=1 and SER_INT_REQ=0 on the next edge.
REQ-033 RESET asserted mid-frame SHALL abort the frame with no TI or RI set.

Verification
REQ-034 Mode 1, SMOD=1, TERM_COUNT1 pulse every 4 cycles, write SBUF=8'hA5 -> TXD bits 0,1,0,1,0,0,1,0,1,1 at 64-cycle spacing; TI=1 at stop-bit start.
REQ-035 Mode 1, REN=1, drive frame 8'h3C with stop=1 -> SBUF read=8'h3C, RB8=1, RI=1, SER_INT_REQ=1.
REQ-036 Mode 3, SM2=1, receive a frame with ninth bit=0 -> RI stays 0 and the buffer is unchanged; with ninth bit=1 -> RI=1.
REQ-037 Apply a 5-cycle low glitch on RXD (shorter than 7 ticks) -> false start, receiver returns to IDLE, RI=0.
REQ-038 Mode 2, SMOD=0, TB8=1, write SBUF=8'h01 -> 11-bit frame at 64 cycles/bit with ninth bit=1.
REQ-039 RI=1 already set, receive another frame -> buffer keeps the old data; and RESET mid-transmission -> TXD_OUT=1 on the next edge.

Source files
------------

// File: rtl/serial_port.sv
// 8051-style serial port: SCON/SBUF SFRs, modes 1-3 UART transmitter and
// receiver with 16x oversampling and 2-of-3 majority bit sampling.
module serial_port #(
  parameter logic [7:0] SCON_ADDRESS = 8'h98,
  parameter logic [7:0] SBUF_ADDRESS = 8'h99
) (
  input  logic       CPUClock,
  input  logic       RESET,
  input  logic [7:0] DIR_RD_ADDRS,
  input  logic [7:0] DIR_WR_ADDRS,
  input  logic [7:0] WR_DATA,
  output logic [7:0] RD_DATA,
  input  logic       WR_EN,
  input  logic       DIRECT_WR,
  input  logic       TERM_COUNT1,
  input  logic       SMOD,
  input  logic       RXD_IN,
  output logic       TXD_OUT,
  output logic       SER_INT_REQ
);

  typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_BIT9, RX_STOP} rx_state_t;

  logic [7:0] scon, sbuf_rx;
  logic [1:0] mode;
  logic       nine_bit, scon_wr, sbuf_wr, mode_chg;

  assign mode     = scon[7:6];
  assign nine_bit = scon[7];
  assign scon_wr  = WR_EN && DIRECT_WR && (DIR_WR_ADDRS == SCON_ADDRESS);
  assign sbuf_wr  = WR_EN && DIRECT_WR && (DIR_WR_ADDRS == SBUF_ADDRESS);
  assign mode_chg = scon_wr && (WR_DATA[7:6] != mode);

  // Sample tick generation (16 ticks per bit)
  logic       tc_half, tick;
  logic [1:0] div;

  always_ff @(posedge CPUClock) begin
    if (RESET) begin
      tc_half <= 1'b0;
      div     <= '0;
    end else begin
      div <= div + 2'd1;
      if (TERM_COUNT1) tc_half <= ~tc_half;
    end
  end

  always_comb begin
    tick = 1'b0;
    case (mode)
      2'b01, 2'b11: tick = TERM_COUNT1 && (SMOD || tc_half);
      2'b10:        tick = SMOD ? div[0] : (div == 2'b11);
      default:      tick = 1'b0;
    endcase
  end

  // Transmitter
  tx_state_t  tx_state, tx_state_n;
  logic [8:0] tx_shift, tx_shift_n;
  logic [3:0] tx_bit, tx_bit_n, tx_cnt, tx_cnt_n, tx_last;
  logic       set_ti;

  always_ff @(posedge CPUClock) begin
    if (RESET) begin
      tx_state <= TX_IDLE;
      tx_shift <= '0;
      tx_bit   <= '0;
      tx_cnt   <= '0;
    end else begin
      tx_state <= tx_state_n;
      tx_shift <= tx_shift_n;
      tx_bit   <= tx_bit_n;
      tx_cnt   <= tx_cnt_n;
    end
  end

  always_comb begin
    tx_state_n = tx_state;
    tx_shift_n = tx_shift;
    tx_bit_n   = tx_bit;
    tx_cnt_n   = tx_cnt;
    set_ti     = 1'b0;
    tx_last    = nine_bit ? 4'd10 : 4'd9;
    case (tx_state)
      TX_IDLE: begin
        if (sbuf_wr && (mode != 2'b00)) begin
          tx_state_n = TX_SEND;
          tx_shift_n = {scon[3], WR_DATA};
          tx_bit_n   = '0;
          tx_cnt_n   = '0;
        end
      end
      TX_SEND: begin
        if (tick) begin
          tx_cnt_n = tx_cnt + 4'd1;
          if (tx_cnt == 4'd15) begin
            if (tx_bit == tx_last) begin
              tx_state_n = TX_IDLE;
            end else begin
              tx_bit_n = tx_bit + 4'd1;
              if ((tx_bit + 4'd1) == tx_last) set_ti = 1'b1;
            end
          end
        end
      end
      default: tx_state_n = TX_IDLE;
    endcase
    if (mode_chg) begin
      tx_state_n = TX_IDLE;
      set_ti     = 1'b0;
    end
  end

  always_comb begin
    TXD_OUT = 1'b1;
    if (tx_state == TX_SEND) begin
      case (tx_bit)
        4'd0:                                    TXD_OUT = 1'b0;
        4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8: TXD_OUT = tx_shift[tx_bit - 4'd1];
        4'd9:                                    TXD_OUT = nine_bit ? tx_shift[8] : 1'b1;
        default:                                 TXD_OUT = 1'b1;
      endcase
    end
  end

  // Receiver
  rx_state_t  rx_state, rx_state_n;
  logic [3:0] rx_cnt, rx_cnt_n;
  logic [2:0] rx_bit, rx_bit_n;
  logic [1:0] rx_votes, rx_votes_n;
  logic [7:0] rx_shift, rx_shift_n;
  logic       rx_nine, rx_nine_n;
  logic       rxd_s1, rxd_s2, rxd_d;
  logic       maj, rb, rx_load, rx_abort;

  always_ff @(posedge CPUClock) begin
    if (RESET) begin
      rxd_s1   <= 1'b1;
      rxd_s2   <= 1'b1;
      rxd_d    <= 1'b1;
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_votes <= '0;
      rx_shift <= '0;
      rx_nine  <= 1'b0;
    end else begin
      rxd_s1   <= RXD_IN;
      rxd_s2   <= rxd_s1;
      rxd_d    <= rxd_s2;
      rx_state <= rx_state_n;
      rx_cnt   <= rx_cnt_n;
      rx_bit   <= rx_bit_n;
      rx_votes <= rx_votes_n;
      rx_shift <= rx_shift_n;
      rx_nine  <= rx_nine_n;
    end
  end

  // Majority uses the two stored votes plus the live third sample
  assign maj      = (rx_votes[0] & rx_votes[1]) | ((rx_votes[0] | rx_votes[1]) & rxd_s2);
  assign rb       = nine_bit ? rx_nine : maj;
  assign rx_abort = !scon[4] || (scon_wr && (!WR_DATA[4] || mode_chg));

  always_comb begin
    rx_state_n = rx_state;
    rx_cnt_n   = rx_cnt;
    rx_bit_n   = rx_bit;
    rx_votes_n = rx_votes;
    rx_shift_n = rx_shift;
    rx_nine_n  = rx_nine;
    rx_load    = 1'b0;
    if (rx_state == RX_IDLE) begin
      if ((mode != 2'b00) && rxd_d && !rxd_s2) begin
        rx_state_n = RX_START;
        rx_cnt_n   = '0;
      end
    end else if (tick) begin
      rx_cnt_n = rx_cnt + 4'd1;
      if (rx_cnt == 4'd7) rx_votes_n[0] = rxd_s2;
      if (rx_cnt == 4'd8) rx_votes_n[1] = rxd_s2;
      if (rx_cnt == 4'd9) begin
        case (rx_state)
          RX_START: if (maj) rx_state_n = RX_IDLE;
          RX_DATA:  rx_shift_n = {maj, rx_shift[7:1]};
          RX_BIT9:  rx_nine_n = maj;
          RX_STOP: begin
            rx_state_n = RX_IDLE;
            rx_load    = !scon[0] && (!scon[5] || rb);
          end
          default:  rx_state_n = RX_IDLE;
        endcase
      end
      if (rx_cnt == 4'd15) begin
        case (rx_state)
          RX_START: begin
            rx_state_n = RX_DATA;
            rx_bit_n   = '0;
          end
          RX_DATA: begin
            if (rx_bit == 3'd7) rx_state_n = nine_bit ? RX_BIT9 : RX_STOP;
            else                rx_bit_n   = rx_bit + 3'd1;
          end
          RX_BIT9: rx_state_n = RX_STOP;
          default: rx_state_n = RX_IDLE;
        endcase
      end
    end
    if (rx_abort) begin
      rx_state_n = RX_IDLE;
      rx_load    = 1'b0;
    end
  end

  // SFRs: hardware flag sets override a same-cycle software write
  always_ff @(posedge CPUClock) begin
    if (RESET) begin
      scon    <= '0;
      sbuf_rx <= '0;
    end else begin
      if (scon_wr) scon <= WR_DATA;
      if (set_ti)  scon[1] <= 1'b1;
      if (rx_load) begin
        scon[0] <= 1'b1;
        scon[2] <= rb;
        sbuf_rx <= rx_shift;
      end
    end
  end

  always_comb begin
    if (DIR_RD_ADDRS == SCON_ADDRESS)      RD_DATA = scon;
    else if (DIR_RD_ADDRS == SBUF_ADDRESS) RD_DATA = sbuf_rx;
    else                                   RD_DATA = 8'h00;
  end

  assign SER_INT_REQ = scon[1] | scon[0];

endmodule

// File: tb/tb_serial_port.sv
// Directed self-checking bench for serial_port: transmit frames, receive
// frames, multiprocessor filtering, false start, RI overrun and reset abort.
module tb_serial_port;

  localparam logic [7:0] SCON_A = 8'h98;
  localparam logic [7:0] SBUF_A = 8'h99;

  logic       CPUClock = 1'b0;
  logic       RESET = 1'b1;
  logic [7:0] DIR_RD_ADDRS = 8'h00;
  logic [7:0] DIR_WR_ADDRS = 8'h00;
  logic [7:0] WR_DATA = 8'h00;
  logic [7:0] RD_DATA;
  logic       WR_EN = 1'b0;
  logic       DIRECT_WR = 1'b0;
  logic       TERM_COUNT1 = 1'b0;
  logic       SMOD = 1'b1;
  logic       RXD_IN = 1'b1;
  logic       TXD_OUT;
  logic       SER_INT_REQ;

  int vectors = 0;
  int miscompares = 0;
  int tc_cnt = 0;
  logic tc_en = 1'b0;
  logic [7:0] rd;

  serial_port #(.SCON_ADDRESS(SCON_A), .SBUF_ADDRESS(SBUF_A)) dut (
    .CPUClock(CPUClock), .RESET(RESET),
    .DIR_RD_ADDRS(DIR_RD_ADDRS), .DIR_WR_ADDRS(DIR_WR_ADDRS),
    .WR_DATA(WR_DATA), .RD_DATA(RD_DATA),
    .WR_EN(WR_EN), .DIRECT_WR(DIRECT_WR),
    .TERM_COUNT1(TERM_COUNT1), .SMOD(SMOD), .RXD_IN(RXD_IN),
    .TXD_OUT(TXD_OUT), .SER_INT_REQ(SER_INT_REQ)
  );

  always #5 CPUClock = ~CPUClock;

  // Timer-1 overflow pulse every 4 cycles
  always @(negedge CPUClock) begin
    tc_cnt = tc_cnt + 1;
    TERM_COUNT1 = tc_en && (tc_cnt % 4 == 0);
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic sfr_write(input logic [7:0] addr, input logic [7:0] data);
    @(negedge CPUClock);
    DIR_WR_ADDRS = addr; WR_DATA = data; WR_EN = 1'b1; DIRECT_WR = 1'b1;
    @(negedge CPUClock);
    WR_EN = 1'b0; DIRECT_WR = 1'b0;
  endtask

  task automatic sfr_read(input logic [7:0] addr, output logic [7:0] d);
    DIR_RD_ADDRS = addr;
    #1 d = RD_DATA;
  endtask

  // Samples mid-bit after an SBUF write; bits[] is in line order
  task automatic tx_expect(input string tag, input logic [10:0] bits, input int nbits, input bit inject);
    logic [7:0] s;
    repeat (32) @(negedge CPUClock);
    for (int k = 0; k < nbits; k++) begin
      chk($sformatf("%s_bit%0d", tag, k), {7'd0, TXD_OUT}, {7'd0, bits[k]});
      if (k == nbits - 2) begin
        sfr_read(SCON_A, s);
        chk($sformatf("%s_ti_before_stop", tag), {7'd0, s[1]}, 8'd0);
      end
      if (k == nbits - 1) begin
        sfr_read(SCON_A, s);
        chk($sformatf("%s_ti_at_stop", tag), {7'd0, s[1]}, 8'd1);
        chk($sformatf("%s_int_req", tag), {7'd0, SER_INT_REQ}, 8'd1);
      end
      if (k == 3 && inject) begin
        sfr_write(SBUF_A, 8'hFF);
        repeat (62) @(negedge CPUClock);
      end else begin
        repeat (64) @(negedge CPUClock);
      end
    end
  endtask

  task automatic send_frame(input logic [7:0] data, input bit has_nine, input bit nine, input bit stop);
    @(negedge CPUClock);
    RXD_IN = 1'b0;
    repeat (64) @(negedge CPUClock);
    for (int i = 0; i < 8; i++) begin
      RXD_IN = data[i];
      repeat (64) @(negedge CPUClock);
    end
    if (has_nine) begin
      RXD_IN = nine;
      repeat (64) @(negedge CPUClock);
    end
    RXD_IN = stop;
    repeat (64) @(negedge CPUClock);
    RXD_IN = 1'b1;
    repeat (8) @(negedge CPUClock);
  endtask

  initial begin
    // Reset state
    @(posedge CPUClock); #1;
    chk("rst_txd", {7'd0, TXD_OUT}, 8'd1);
    chk("rst_int", {7'd0, SER_INT_REQ}, 8'd0);
    sfr_read(SCON_A, rd); chk("rst_scon", rd, 8'h00);
    sfr_read(SBUF_A, rd); chk("rst_sbuf", rd, 8'h00);
    repeat (2) @(negedge CPUClock);
    RESET = 1'b0;
    tc_en = 1'b1;
    SMOD  = 1'b1;

    // Mode 1 transmit 8'hA5
    sfr_write(SCON_A, 8'h40);
    sfr_read(SCON_A, rd); chk("scon_wr_readback", rd, 8'h40);
    sfr_write(SBUF_A, 8'hA5);
    tx_expect("m1_tx_a5", {1'b0, 1'b1, 8'hA5, 1'b0}, 10, 1'b0);

    // Mode 1 receive 8'h3C
    sfr_write(SCON_A, 8'h50);
    send_frame(8'h3C, 1'b0, 1'b0, 1'b1);
    sfr_read(SBUF_A, rd); chk("m1_rx_data", rd, 8'h3C);
    sfr_read(SCON_A, rd);
    chk("m1_rx_rb8", {7'd0, rd[2]}, 8'd1);
    chk("m1_rx_ri", {7'd0, rd[0]}, 8'd1);
    chk("m1_rx_int", {7'd0, SER_INT_REQ}, 8'd1);
    sfr_read(8'h80, rd); chk("unmapped_read", rd, 8'h00);

    // RI still set: next frame must be discarded
    send_frame(8'h81, 1'b0, 1'b0, 1'b1);
    sfr_read(SBUF_A, rd); chk("ri_overrun_keep", rd, 8'h3C);

    // Mode 3 multiprocessor filtering
    sfr_write(SCON_A, 8'hF0);
    send_frame(8'h55, 1'b1, 1'b0, 1'b1);
    sfr_read(SCON_A, rd); chk("m3_sm2_nine0_ri", {7'd0, rd[0]}, 8'd0);
    sfr_read(SBUF_A, rd); chk("m3_sm2_nine0_buf", rd, 8'h3C);
    send_frame(8'hC3, 1'b1, 1'b1, 1'b1);
    sfr_read(SCON_A, rd);
    chk("m3_sm2_nine1_ri", {7'd0, rd[0]}, 8'd1);
    chk("m3_sm2_nine1_rb8", {7'd0, rd[2]}, 8'd1);
    sfr_read(SBUF_A, rd); chk("m3_sm2_nine1_buf", rd, 8'hC3);

    // False start, then receiver must re-arm
    sfr_write(SCON_A, 8'h50);
    @(negedge CPUClock);
    RXD_IN = 1'b0;
    repeat (5) @(negedge CPUClock);
    RXD_IN = 1'b1;
    repeat (100) @(negedge CPUClock);
    sfr_read(SCON_A, rd); chk("glitch_ri", {7'd0, rd[0]}, 8'd0);
    sfr_read(SBUF_A, rd); chk("glitch_buf", rd, 8'hC3);
    send_frame(8'h5A, 1'b0, 1'b0, 1'b1);
    sfr_read(SBUF_A, rd); chk("rearm_buf", rd, 8'h5A);

    // Mode 2, SMOD=0, TB8=1; SBUF write mid-frame is ignored
    SMOD = 1'b0;
    sfr_write(SCON_A, 8'h88);
    sfr_write(SBUF_A, 8'h01);
    tx_expect("m2_tx_01", {1'b1, 1'b1, 8'h01, 1'b0}, 11, 1'b1);

    // Reset mid-transmission
    SMOD = 1'b1;
    sfr_write(SCON_A, 8'h40);
    sfr_write(SBUF_A, 8'h00);
    repeat (96) @(negedge CPUClock);
    chk("pre_reset_txd", {7'd0, TXD_OUT}, 8'd0);
    @(negedge CPUClock);
    RESET = 1'b1;
    @(posedge CPUClock); #1;
    chk("mid_reset_txd", {7'd0, TXD_OUT}, 8'd1);
    chk("mid_reset_int", {7'd0, SER_INT_REQ}, 8'd0);
    @(negedge CPUClock);
    RESET = 1'b0;
    repeat (700) @(negedge CPUClock);
    sfr_read(SCON_A, rd); chk("post_reset_scon", rd, 8'h00);
    sfr_read(SBUF_A, rd); chk("post_reset_sbuf", rd, 8'h00);
    chk("post_reset_txd", {7'd0, TXD_OUT}, 8'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
